// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetchState_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_rvalid, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_rvalid, imem_rdata);

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush and empty cycles load a NOP bubble, stall freezes it.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] fetchInstr,
    input  logic [31:0] fetchPc,
    input  logic [31:0] fetchPcPlus4,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (flush) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                InstrD   <= fetchInstr;
                PCD      <= fetchPc;
                PCPlus4D <= fetchPcPlus4;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding request FSM and 1-entry hold buffer feeding IF/ID.
// Optional FetchCount/WaitCycles performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    fetch_if.master     imem,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        IMemWait
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] WaitCycles
`endif
);

    localparam logic [1:0] StIdle  = IDLE;
    localparam logic [1:0] StWait  = WAIT;
    localparam logic [1:0] StDrain = DRAIN;

    logic [1:0]  state, stateNext;
    logic [31:0] pcF, pcNext, pcPlus4F;
    logic        holdValid, holdValidNext;
    logic [31:0] holdData, holdDataNext;
    logic        reqValid;
    logic [31:0] reqAddr;
    logic        ifidLoad;
    logic [31:0] ifidInstr;
    logic        advance;

    assign pcPlus4F = pcF + 32'd4;
    // A word may enter IF/ID only when decode neither holds nor kills it this cycle.
    assign advance  = !StallD && !FlushD;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext     = state;
        pcNext        = pcF;
        holdValidNext = holdValid;
        holdDataNext  = holdData;
        reqValid      = 1'b0;
        reqAddr       = pcF;
        ifidLoad      = 1'b0;
        ifidInstr     = holdData;
        case (state)
            StIdle: begin
                if (PCSrcE) begin
                    pcNext        = PCTargetE;
                    holdValidNext = 1'b0;
                end else if (!holdValid) begin
                    reqValid  = 1'b1;
                    stateNext = StWait;
                end else if (advance) begin
                    ifidLoad      = 1'b1;
                    pcNext        = pcPlus4F;
                    reqValid      = 1'b1;
                    reqAddr       = pcPlus4F;
                    holdValidNext = 1'b0;
                    stateNext     = StWait;
                end
            end
            StWait: begin
                if (PCSrcE) begin
                    pcNext    = PCTargetE;
                    stateNext = imem.imem_rvalid ? StIdle : StDrain;
                end else if (imem.imem_rvalid) begin
                    if (advance) begin
                        ifidLoad  = 1'b1;
                        ifidInstr = imem.imem_rdata;
                        pcNext    = pcPlus4F;
                        reqValid  = 1'b1;
                        reqAddr   = pcPlus4F;
                    end else begin
                        holdValidNext = 1'b1;
                        holdDataNext  = imem.imem_rdata;
                        stateNext     = StIdle;
                    end
                end
            end
            StDrain: begin
                if (PCSrcE) begin
                    pcNext = PCTargetE;
                end
                // The stale response retires the outstanding request whatever else happens.
                if (imem.imem_rvalid) begin
                    stateNext = StIdle;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    // Gated with rst_n so no request leaves the block while reset is held.
    assign imem.imem_req  = rst_n && reqValid;
    assign imem.imem_addr = reqAddr;
    assign IMemWait       = (state == StWait && !imem.imem_rvalid) || state == StDrain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            pcF       <= RESET_VECTOR;
            holdValid <= 1'b0;
        end else begin
            state     <= stateNext;
            pcF       <= pcNext;
            holdValid <= holdValidNext;
        end
    end

    // NOTE: the hold data is qualified by holdValid, so it carries no reset.
    always_ff @(posedge clk) begin
        holdData <= holdDataNext;
    end

    ifid_reg u_ifid (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (StallD),
        .flush        (FlushD || PCSrcE),
        .load         (ifidLoad),
        .fetchInstr   (ifidInstr),
        .fetchPc      (pcF),
        .fetchPcPlus4 (pcPlus4F),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FetchCount <= 32'h0;
            WaitCycles <= 32'h0;
        end else begin
            if (ifidLoad) FetchCount <= FetchCount + 32'd1;
            if (IMemWait) WaitCycles <= WaitCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory model and hand-computed checks.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, IMemWait;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount, WaitCycles;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    fetch_if bus ();

    fetch_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem      (bus.master),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .IMemWait  (IMemWait)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount(FetchCount),
        .WaitCycles(WaitCycles)
`endif
    );

    always #5 clk = ~clk;

    // Memory image: word at address a is 0x00A00093 + a.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h00A0_0093 + a;
    endfunction

    // Memory model: responds memLat cycles after a request; deliberately ignores reset
    // so a response to a pre-reset request can still arrive late.
    int          memLat = 1;
    int          cyc = 0;
    logic        pendValid = 1'b0;
    int          pendDue = 0;
    logic [31:0] pendAddr = 32'h0;

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pendValid && pendDue == cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = memWord(pendAddr);
                pendValid       = 1'b0;
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (bus.imem_req === 1'b1) begin
                pendValid = 1'b1;
                pendDue   = cyc + memLat;
                pendAddr  = bus.imem_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start of a cycle: inputs change 2 units after the edge, checks follow 1 unit later.
    task automatic cycleIn(input logic stall, input logic flush, input logic pcSrc,
                           input logic [31:0] target);
        @(posedge clk);
        #2;
        StallD    = stall;
        FlushD    = flush;
        PCSrcE    = pcSrc;
        PCTargetE = target;
        #1;
    endtask

    initial begin
        rst_n = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_instr",   InstrD,   NOP);
        check("rst_pcd",     PCD,      32'h0);
        check("rst_pcp4",    PCPlus4D, 32'h0);
        check("rst_valid",   ValidD,   1'b0);
        check("rst_req",     bus.imem_req, 1'b0);
        check("rst_wait",    IMemWait, 1'b0);

        // Reset release, latency 1: back-to-back fetch
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("c0_req",  bus.imem_req,  1'b1);
        check("c0_addr", bus.imem_addr, 32'h0);
        check("c0_wait", IMemWait,      1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("c1_req",   bus.imem_req,  1'b1);
        check("c1_addr",  bus.imem_addr, 32'h4);
        check("c1_valid", ValidD,        1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("c2_instr", InstrD,        32'h00A0_0093);
        check("c2_valid", ValidD,        1'b1);
        check("c2_pcd",   PCD,           32'h0);
        check("c2_pcp4",  PCPlus4D,      32'h4);
        check("c2_addr",  bus.imem_addr, 32'h8);
        cycleIn(0, 0, 0, 32'h0);
        check("c3_instr", InstrD, 32'h00A0_0097);
        check("c3_pcd",   PCD,    32'h4);

        // StallD for 3 cycles while the response for 0xC arrives
        cycleIn(1, 0, 0, 32'h0);
        check("st0_req",   bus.imem_req, 1'b0);
        check("st0_instr", InstrD,       32'h00A0_009B);
        check("st0_pcd",   PCD,          32'h8);
        cycleIn(1, 0, 0, 32'h0);
        check("st1_req",   bus.imem_req, 1'b0);
        check("st1_instr", InstrD,       32'h00A0_009B);
        cycleIn(1, 0, 0, 32'h0);
        check("st2_instr", InstrD,       32'h00A0_009B);
        check("st2_valid", ValidD,       1'b1);
        check("st2_req",   bus.imem_req, 1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("st3_req",   bus.imem_req,  1'b1);
        check("st3_addr",  bus.imem_addr, 32'h10);
        check("st3_instr", InstrD,        32'h00A0_009B);
        cycleIn(0, 0, 0, 32'h0);
        check("st4_instr", InstrD,        32'h00A0_009F);
        check("st4_pcd",   PCD,           32'hC);
        check("st4_pcp4",  PCPlus4D,      32'h10);
        check("st4_addr",  bus.imem_addr, 32'h14);
        memLat = 3;

        // Latency 3: two bubbles and two wait cycles per fetch
        cycleIn(0, 0, 0, 32'h0);
        check("l3a_wait",  IMemWait,     1'b1);
        check("l3a_req",   bus.imem_req, 1'b0);
        check("l3a_instr", InstrD,       32'h00A0_00A3);
        check("l3a_valid", ValidD,       1'b1);
        cycleIn(0, 0, 0, 32'h0);
        check("l3b_wait",  IMemWait, 1'b1);
        check("l3b_valid", ValidD,   1'b0);
        check("l3b_instr", InstrD,   NOP);
        cycleIn(0, 0, 0, 32'h0);
        check("l3c_wait",  IMemWait,      1'b0);
        check("l3c_valid", ValidD,        1'b0);
        check("l3c_req",   bus.imem_req,  1'b1);
        check("l3c_addr",  bus.imem_addr, 32'h18);

        // Redirect to 0x100 while the 0x18 request is outstanding -> DRAIN
        cycleIn(0, 0, 1, 32'h100);
        check("rd0_instr", InstrD,       32'h00A0_00A7);
        check("rd0_pcd",   PCD,          32'h14);
        check("rd0_wait",  IMemWait,     1'b1);
        check("rd0_req",   bus.imem_req, 1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("rd1_wait",  IMemWait,     1'b1);
        check("rd1_valid", ValidD,       1'b0);
        check("rd1_req",   bus.imem_req, 1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("rd2_wait", IMemWait,     1'b1);
        check("rd2_req",  bus.imem_req, 1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("rd3_req",   bus.imem_req,  1'b1);
        check("rd3_addr",  bus.imem_addr, 32'h100);
        check("rd3_valid", ValidD,        1'b0);
        check("rd3_instr", InstrD,        NOP);
        cycleIn(0, 0, 0, 32'h0);
        check("rd4_valid", ValidD, 1'b0);
        cycleIn(0, 0, 0, 32'h0);
        cycleIn(0, 0, 0, 32'h0);
        check("rd6_addr", bus.imem_addr, 32'h104);
        cycleIn(0, 0, 0, 32'h0);
        check("rd7_instr", InstrD,   32'h00A0_0193);
        check("rd7_valid", ValidD,   1'b1);
        check("rd7_pcd",   PCD,      32'h100);
        check("rd7_pcp4",  PCPlus4D, 32'h104);
        cycleIn(0, 0, 0, 32'h0);

        // Redirect coincident with the response for 0x104
        cycleIn(0, 0, 1, 32'h100);
        check("rc0_req", bus.imem_req, 1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("rc1_req",   bus.imem_req,  1'b1);
        check("rc1_addr",  bus.imem_addr, 32'h100);
        check("rc1_valid", ValidD,        1'b0);
        check("rc1_instr", InstrD,        NOP);

        // Reset mid-WAIT; the late response lands in the first cycle after release
        cycleIn(0, 0, 0, 32'h0);
        check("mr_wait_pre", IMemWait, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_instr", InstrD,       NOP);
        check("mr_pcd",   PCD,          32'h0);
        check("mr_pcp4",  PCPlus4D,     32'h0);
        check("mr_valid", ValidD,       1'b0);
        check("mr_req",   bus.imem_req, 1'b0);
        check("mr_wait",  IMemWait,     1'b0);
        cycleIn(0, 0, 0, 32'h0);
        @(posedge clk);
        #2;
        memLat = 1;
        rst_n  = 1'b1;
        #1;
        check("mr0_req",  bus.imem_req,  1'b1);
        check("mr0_addr", bus.imem_addr, 32'h0);
        check("mr0_wait", IMemWait,      1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("mr1_valid", ValidD,        1'b0);
        check("mr1_instr", InstrD,        NOP);
        check("mr1_addr",  bus.imem_addr, 32'h4);

        // FlushD with StallD: IF/ID gets a bubble, the fetched word is held
        cycleIn(1, 1, 0, 32'h0);
        check("fl0_instr", InstrD,       32'h00A0_0093);
        check("fl0_valid", ValidD,       1'b1);
        check("fl0_req",   bus.imem_req, 1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("fl1_instr", InstrD,        NOP);
        check("fl1_valid", ValidD,        1'b0);
        check("fl1_req",   bus.imem_req,  1'b1);
        check("fl1_addr",  bus.imem_addr, 32'h8);

        // Redirect to the top of the address space: PC+4 wraps to 0
        cycleIn(0, 0, 1, 32'hFFFF_FFFC);
        check("wr0_instr", InstrD,       32'h00A0_0097);
        check("wr0_pcd",   PCD,          32'h4);
        check("wr0_req",   bus.imem_req, 1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("wr1_addr",  bus.imem_addr, 32'hFFFF_FFFC);
        check("wr1_valid", ValidD,        1'b0);
        cycleIn(0, 0, 0, 32'h0);
        check("wr2_req",  bus.imem_req,  1'b1);
        check("wr2_addr", bus.imem_addr, 32'h0);
        cycleIn(0, 0, 0, 32'h0);
        check("wr3_instr", InstrD,   32'h00A0_008F);
        check("wr3_pcd",   PCD,      32'hFFFF_FFFC);
        check("wr3_pcp4",  PCPlus4D, 32'h0);
        check("wr3_valid", ValidD,   1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
